// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and feeder state type
package audio_pkg;
  localparam int DATA_WIDTH = 24;
  localparam int N          = 1024;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/sample_feeder_if.sv
// rtl/sample_feeder_if.sv - sample input / issue output bundle of the feeder
interface sample_feeder_if #(
  parameter int data_width = audio_pkg::DATA_WIDTH,
  parameter int N          = audio_pkg::N,
  parameter int depth      = audio_pkg::FIFO_DEPTH
);
  logic                    sample_valid;
  logic [data_width-1:0]   sample_in;
  logic                    conv_done;
  logic                    read;
  logic [data_width-1:0]   data_out;
  logic [$clog2(N)-1:0]    frame_idx;
  logic                    frame_last;
  logic [$clog2(depth):0]  fifo_count;
  logic                    overflow;
  logic                    timeout_err;

  modport master (
    output sample_valid, sample_in, conv_done,
    input  read, data_out, frame_idx, frame_last, fifo_count, overflow, timeout_err
  );

  modport slave (
    input  sample_valid, sample_in, conv_done,
    output read, data_out, frame_idx, frame_last, fifo_count, overflow, timeout_err
  );
endinterface

// File: rtl/sample_feeder_fifo.sv
// rtl/sample_feeder_fifo.sv - sample_fifo: power-of-two FIFO with show-ahead head
module sample_fifo #(
  parameter int data_width = 24,
  parameter int depth      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [data_width-1:0]  wr_data_i,
  output logic [data_width-1:0]  rd_data_o,
  output logic [$clog2(depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(depth);

  logic [data_width-1:0] mem_q [depth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // a full FIFO still accepts a write when the head leaves on the same edge
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - buffers audio samples and issues them one at a time to a converter
module sample_feeder #(
  parameter int N          = audio_pkg::N,
  parameter int data_width = audio_pkg::DATA_WIDTH,
  parameter int depth      = audio_pkg::FIFO_DEPTH,
  parameter int timeout    = audio_pkg::TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  sample_feeder_if.slave bus
);
  import audio_pkg::*;

  localparam int IW = $clog2(N);
  localparam int TW = (timeout > 1) ? $clog2(timeout) : 1;

  feeder_state_e          state_q, state_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic [data_width-1:0]  data_q, data_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          pop_cnt_q, pop_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   tmo_q, tmo_d;
  logic                   pop;
  logic                   fifo_full, fifo_empty;
  logic [data_width-1:0]  fifo_head;
  logic [$clog2(depth):0] fifo_count;

  sample_fifo #(.data_width(data_width), .depth(depth)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.sample_valid),
    .pop_i     (pop),
    .wr_data_i (bus.sample_in),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    data_d     = data_q;
    idx_d      = idx_q;
    pop_cnt_d  = pop_cnt_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (bus.sample_valid & fifo_full & ~pop);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_d    = fifo_head;
          idx_d     = pop_cnt_q;
          pop_cnt_d = pop_cnt_q + IW'(1);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.conv_done) begin
          state_d = IDLE;
        end else if (wait_q == TW'(timeout - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = overflow_q | (bus.sample_valid & fifo_full & ~pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      pop_cnt_q  <= '0;
      overflow_q <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      pop_cnt_q  <= pop_cnt_d;
      overflow_q <= overflow_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.read        = (state_q == ISSUE);
  assign bus.data_out    = data_q;
  assign bus.frame_idx   = idx_q;
  assign bus.frame_last  = (state_q == ISSUE) && (idx_q == IW'(N - 1));
  assign bus.fifo_count  = fifo_count;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - directed self-checking bench for sample_feeder
module tb_sample_feeder;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   read_cnt = 0;

  always #5 clk = ~clk;

  sample_feeder_if #(.data_width(24), .N(1024), .depth(16)) bus ();

  sample_feeder #(.N(1024), .data_width(24), .depth(16), .timeout(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.read === 1'b1) read_cnt++;

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.conv_done    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [23:0] v);
    bus.sample_valid = 1'b1;
    bus.sample_in    = v;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_read(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.read === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.read !== 1'b0)          begin failures++; $display("FAIL rst_read got=%0h want=0", bus.read); end
    checks++; if (bus.data_out !== 24'h0)     begin failures++; $display("FAIL rst_data got=%0h want=0", bus.data_out); end
    checks++; if (bus.frame_idx !== 10'd0)    begin failures++; $display("FAIL rst_idx got=%0d want=0", bus.frame_idx); end
    checks++; if (bus.frame_last !== 1'b0)    begin failures++; $display("FAIL rst_last got=%0h want=0", bus.frame_last); end
    checks++; if (bus.fifo_count !== 5'd0)    begin failures++; $display("FAIL rst_count got=%0d want=0", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0)      begin failures++; $display("FAIL rst_ovf got=%0h want=0", bus.overflow); end
    checks++; if (bus.timeout_err !== 1'b0)   begin failures++; $display("FAIL rst_tmo got=%0h want=0", bus.timeout_err); end
  endtask

  task automatic test_single();
    int r0;
    do_reset();
    r0 = read_cnt;
    push(24'h000123);
    checks++; if (bus.fifo_count !== 5'd1)    begin failures++; $display("FAIL single_cnt1 got=%0d want=1", bus.fifo_count); end
    checks++; if (bus.read !== 1'b0)          begin failures++; $display("FAIL single_early got=%0h want=0", bus.read); end
    @(negedge clk);
    checks++; if (bus.read !== 1'b1)          begin failures++; $display("FAIL single_read got=%0h want=1", bus.read); end
    checks++; if (bus.data_out !== 24'h000123) begin failures++; $display("FAIL single_data got=%0h want=123", bus.data_out); end
    checks++; if (bus.frame_idx !== 10'd0)    begin failures++; $display("FAIL single_idx got=%0d want=0", bus.frame_idx); end
    checks++; if (bus.fifo_count !== 5'd0)    begin failures++; $display("FAIL single_cnt0 got=%0d want=0", bus.fifo_count); end
    @(negedge clk);
    @(negedge clk);
    bus.conv_done = 1'b1;
    @(negedge clk);
    bus.conv_done = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (read_cnt - r0 !== 1)        begin failures++; $display("FAIL single_pulses got=%0d want=1", read_cnt - r0); end
    checks++; if (bus.data_out !== 24'h000123) begin failures++; $display("FAIL single_hold got=%0h want=123", bus.data_out); end
    checks++; if (bus.timeout_err !== 1'b0)   begin failures++; $display("FAIL single_tmo got=%0h want=0", bus.timeout_err); end
  endtask

  task automatic test_overflow();
    int r0;
    do_reset();
    r0 = read_cnt;
    for (int i = 0; i < 17; i++) push(24'h000100 + 24'(i));
    checks++; if (bus.fifo_count !== 5'd16)   begin failures++; $display("FAIL ovf_cnt got=%0d want=16", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0)      begin failures++; $display("FAIL ovf_early got=%0h want=0", bus.overflow); end
    checks++; if (read_cnt - r0 !== 1)        begin failures++; $display("FAIL ovf_pulses got=%0d want=1", read_cnt - r0); end
    checks++; if (bus.data_out !== 24'h000100) begin failures++; $display("FAIL ovf_first got=%0h want=100", bus.data_out); end
    push(24'h0001FF);
    checks++; if (bus.overflow !== 1'b1)      begin failures++; $display("FAIL ovf_set got=%0h want=1", bus.overflow); end
    checks++; if (bus.fifo_count !== 5'd16)   begin failures++; $display("FAIL ovf_cnt2 got=%0d want=16", bus.fifo_count); end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    logic [23:0] exp;
    do_reset();
    for (int i = 0; i < 17; i++) push(24'h000100 + 24'(i));
    bus.conv_done = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 24'h000300;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    checks++; if (bus.fifo_count !== 5'd16)   begin failures++; $display("FAIL fpp_cnt got=%0d want=16", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0)      begin failures++; $display("FAIL fpp_ovf got=%0h want=0", bus.overflow); end
    checks++; if (bus.read !== 1'b1)          begin failures++; $display("FAIL fpp_read got=%0h want=1", bus.read); end
    checks++; if (bus.data_out !== 24'h000101) begin failures++; $display("FAIL fpp_head got=%0h want=101", bus.data_out); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 24'h000300 : 24'h000102 + 24'(i);
      @(negedge clk);
      wait_read(10, ok);
      checks++; if (!ok)                      begin failures++; $display("FAIL fpp_timeout got=noread want=read i=%0d", i); end
      checks++; if (bus.data_out !== exp)     begin failures++; $display("FAIL fpp_order got=%0h want=%0h", bus.data_out, exp); end
    end
    checks++; if (bus.fifo_count !== 5'd0)    begin failures++; $display("FAIL fpp_drain got=%0d want=0", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0)      begin failures++; $display("FAIL fpp_ovf_end got=%0h want=0", bus.overflow); end
    bus.conv_done = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    push(24'h004444);
    @(negedge clk);
    checks++; if (bus.read !== 1'b1)          begin failures++; $display("FAIL tmo_read got=%0h want=1", bus.read); end
    cyc = 0;
    push(24'h005555);
    cyc++;
    while (bus.timeout_err !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 65)                 begin failures++; $display("FAIL tmo_cycles got=%0d want=65", cyc); end
    @(negedge clk);
    checks++; if (bus.read !== 1'b1)          begin failures++; $display("FAIL tmo_next_read got=%0h want=1", bus.read); end
    checks++; if (bus.data_out !== 24'h005555) begin failures++; $display("FAIL tmo_next_data got=%0h want=5555", bus.data_out); end
    checks++; if (bus.frame_idx !== 10'd1)    begin failures++; $display("FAIL tmo_next_idx got=%0d want=1", bus.frame_idx); end
    checks++; if (bus.timeout_err !== 1'b1)   begin failures++; $display("FAIL tmo_sticky got=%0h want=1", bus.timeout_err); end
  endtask

  task automatic test_frame();
    bit ok;
    logic [9:0] exp_idx;
    do_reset();
    bus.conv_done = 1'b1;
    for (int i = 0; i < 1025; i++) begin
      exp_idx = i[9:0];
      push(24'(i));
      wait_read(10, ok);
      checks++; if (!ok)                      begin failures++; $display("FAIL frame_timeout got=noread want=read i=%0d", i); end
      checks++; if (bus.frame_idx !== exp_idx) begin failures++; $display("FAIL frame_idx got=%0d want=%0d", bus.frame_idx, exp_idx); end
      checks++; if (bus.frame_last !== (i == 1023)) begin failures++; $display("FAIL frame_last got=%0h want=%0h i=%0d", bus.frame_last, (i == 1023), i); end
      checks++; if (bus.data_out !== 24'(i))  begin failures++; $display("FAIL frame_data got=%0h want=%0h", bus.data_out, i); end
      @(negedge clk);
    end
    bus.conv_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int r0;
    do_reset();
    for (int i = 0; i < 6; i++) push(24'h000600 + 24'(i));
    checks++; if (bus.fifo_count !== 5'd5)    begin failures++; $display("FAIL rmw_queued got=%0d want=5", bus.fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (bus.read !== 1'b0)          begin failures++; $display("FAIL rmw_read got=%0h want=0", bus.read); end
    checks++; if (bus.data_out !== 24'h0)     begin failures++; $display("FAIL rmw_data got=%0h want=0", bus.data_out); end
    checks++; if (bus.fifo_count !== 5'd0)    begin failures++; $display("FAIL rmw_cnt got=%0d want=0", bus.fifo_count); end
    checks++; if (bus.frame_idx !== 10'd0)    begin failures++; $display("FAIL rmw_idx got=%0d want=0", bus.frame_idx); end
    @(negedge clk);
    rst = 1'b0;
    r0 = read_cnt;
    repeat (10) @(negedge clk);
    checks++; if (read_cnt - r0 !== 0)        begin failures++; $display("FAIL rmw_spurious got=%0d want=0", read_cnt - r0); end
    push(24'h000777);
    @(negedge clk);
    checks++; if (bus.read !== 1'b1)          begin failures++; $display("FAIL rmw_new_read got=%0h want=1", bus.read); end
    checks++; if (bus.data_out !== 24'h000777) begin failures++; $display("FAIL rmw_new_data got=%0h want=777", bus.data_out); end
    checks++; if (bus.frame_idx !== 10'd0)    begin failures++; $display("FAIL rmw_new_idx got=%0d want=0", bus.frame_idx); end
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.conv_done    = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_frame();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter N, default 1024: samples per frame (power of two).
REQ-002 Parameter data_width, default 24: audio sample width.
REQ-003 Parameter depth, default 16: FIFO entries (power of two).
REQ-004 Parameter timeout, default 64: max cycles to wait for conversion done.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sample_valid  in  1  one-cycle strobe; sample_in is valid.
REQ-008 sample_in  in  data_width  signed two's-complement audio sample.
REQ-009 conv_done  in  1  downstream int-to-float stage finished the current sample.
REQ-010 read  out  1  one-cycle pulse; downstream captures data_out.
REQ-011 data_out  out  data_width  sample being issued; held stable between read pulses.
REQ-012 frame_idx  out  log2(N)  index within the frame of the sample on data_out.
REQ-013 frame_last  out  1  high with read when frame_idx == N-1.
REQ-014 fifo_count  out  log2(depth)+1  current FIFO occupancy.
REQ-015 overflow  out  1  sticky; a sample was dropped.
REQ-016 timeout_err  out  1  sticky; conv_done was not received in time.

Function
REQ-017 The FIFO SHALL write sample_in on any cycle where sample_valid=1 and the FIFO is not full, or is full with a pop in the same cycle.
REQ-018 When sample_valid=1, the FIFO is full and no pop occurs, the sample SHALL be dropped, overflow set, and occupancy unchanged.
REQ-019 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-020 IDLE -> ISSUE when fifo_count>0: pop the head into data_out on that edge; otherwise remain in IDLE.
REQ-021 In ISSUE, read=1 for exactly one cycle, then -> WAIT unconditionally.
REQ-022 WAIT -> IDLE on conv_done=1; the wait counter is cleared on entry to WAIT.
REQ-023 In WAIT, if the wait counter reaches timeout-1 without conv_done, the FSM SHALL -> IDLE and set timeout_err.
REQ-024 conv_done in IDLE or ISSUE SHALL be ignored.
REQ-025 Latency: a sample written into an empty FIFO with the FSM in IDLE at edge t SHALL appear on data_out at t+1, with read=1 during cycle t+1..t+2.
REQ-026 Minimum spacing between read pulses SHALL be 3 cycles: ISSUE, WAIT with done, IDLE pop.
REQ-027 frame_idx SHALL increment by one at each pop, wrapping from N-1 to 0.
REQ-028 frame_last SHALL equal read AND (frame_idx == N-1).
REQ-029 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO order is strictly FIFO.
REQ-030 Overflow and timeout_err SHALL clear only on reset.

Reset
REQ-031 On rst=1, asynchronously: FSM=IDLE, FIFO empty, fifo_count=0, read=0, data_out=0, frame_idx=0, frame_last=0, overflow=0, timeout_err=0, wait counter=0.
REQ-032 Reset mid-WAIT SHALL discard the in-flight sample and all FIFO contents; no read is issued until a new sample is written.

Structure
REQ-033 The shared package audio_pkg SHALL hold DATA_WIDTH, N, the default FIFO depth and the feeder state enum.
REQ-034 The FIFO SHALL be the sub-module sample_fifo (push, pop, data, count, full, empty), with the same asynchronous reset.

Verification
REQ-035 Reset, then one sample 0x000123 with conv_done returned 2 cycles after read -> exactly one read pulse, data_out=0x000123, frame_idx=0, fifo_count returns to 0.
REQ-036 17 back-to-back samples with conv_done held 0 and timeout large -> first sample popped, 16 buffered, no drop, overflow=0; an 18th sample sets overflow=1.
REQ-037 Never assert conv_done after a read -> exactly 64 cycles later the FSM returns to IDLE, timeout_err=1, and the next sample issues.
REQ-038 Feed 1025 samples with immediate conv_done -> frame_last high only on the 1024th read (frame_idx=1023); the 1025th read shows frame_idx=0.
REQ-039 Assert rst during WAIT with 5 samples queued -> all outputs go to reset values immediately, and no read occurs until a new sample_valid.
REQ-040 sample_valid and a pop in the same cycle while full -> fifo_count stays at 16, overflow=0, and output order is preserved.
